// File: rtl/mem_q_pkg.sv
// Shared definitions for the memory-stage queue: load op codes and the stored entry layout.
package mem_q_pkg;

  typedef enum logic [3:0] {
    OpLdB  = 4'd0,
    OpLdH  = 4'd1,
    OpLdW  = 4'd2,
    OpLdBu = 4'd8,
    OpLdHu = 4'd9
  } load_op_e;

  // Per-entry payload captured at enqueue; valid/received flags and load data live beside it.
  typedef struct packed {
    logic        wait_ok;
    logic [3:0]  mem_op;
    logic        res_from_mem;
    logic        rf_we;
    logic [4:0]  rf_waddr;
    logic [31:0] alu_result;
    logic        ex;
  } mem_entry_t;

endpackage

// File: rtl/load_align.sv
// Load data extraction: selects and extends the addressed byte/halfword/word of a response.
module load_align
  import mem_q_pkg::*;
(
  input  logic [3:0]  mem_op,
  input  logic [1:0]  addr_lo,
  input  logic [31:0] rdata,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[7:0];
    unique case (addr_lo)
      2'd0: byte_sel = rdata[7:0];
      2'd1: byte_sel = rdata[15:8];
      2'd2: byte_sel = rdata[23:16];
      2'd3: byte_sel = rdata[31:24];
      default: byte_sel = rdata[7:0];
    endcase
    half_sel = addr_lo[1] ? rdata[31:16] : rdata[15:0];

    data = '0;
    case (mem_op)
      OpLdB:   data = {{24{byte_sel[7]}}, byte_sel};
      OpLdH:   data = {{16{half_sel[15]}}, half_sel};
      OpLdW:   data = rdata;
      OpLdBu:  data = {24'd0, byte_sel};
      OpLdHu:  data = {16'd0, half_sel};
      default: data = '0;
    endcase
  end

endmodule

// File: rtl/mem_stage_q.sv
// Memory stage as an in-order queue of in-flight instructions; load responses return in order
// and are matched to the oldest entry still waiting, with stale responses discarded after flush.
module mem_stage_q
  import mem_q_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned INFO_W = 64
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wait_ok,
  input  logic [3:0]        in_mem_op,
  input  logic              in_res_from_mem,
  input  logic              in_rf_we,
  input  logic [4:0]        in_rf_waddr,
  input  logic [31:0]       in_alu_result,
  input  logic              in_ex,
  input  logic [INFO_W-1:0] in_info,
  input  logic              data_ok,
  input  logic [31:0]       rdata,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_rf_we,
  output logic [4:0]        out_rf_waddr,
  output logic [31:0]       out_rf_wdata,
  output logic              out_ex,
  output logic [INFO_W-1:0] out_info,
  output logic              fwd_we,
  output logic [4:0]        fwd_waddr,
  output logic [31:0]       fwd_wdata,
  output logic              fwd_load_pending,
  output logic              mem_ex_any
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  mem_entry_t        ent_q  [DEPTH];
  logic [INFO_W-1:0] info_q [DEPTH];
  logic [31:0]       data_q [DEPTH];

  logic [DEPTH-1:0] valid_q, valid_d;
  logic [DEPTH-1:0] recv_q, recv_d;
  logic [PtrW-1:0]  wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [CntW-1:0]  discard_q, discard_d;

  logic            enq, deq, active;
  logic            take_discard, take_entry;
  logic            resp_found;
  logic [PtrW-1:0] resp_idx, scan_idx, young_idx;
  logic [CntW-1:0] pending;
  logic [CntW:0]   disc_sum;
  logic [CntW-1:0] disc_flush;
  logic            head_done, head_hit;
  logic [31:0]     head_rdata, load_data;
  mem_entry_t      head_ent, young_ent;

  // Oldest valid entry still waiting for its data; scanning from the head gives age order.
  always_comb begin
    resp_found = 1'b0;
    resp_idx   = rptr_q;
    scan_idx   = rptr_q;
    pending    = '0;
    for (int i = 0; i < DEPTH; i++) begin
      scan_idx = rptr_q + PtrW'(i);
      if (valid_q[scan_idx] && ent_q[scan_idx].wait_ok && !recv_q[scan_idx]) begin
        pending = pending + 1'b1;
        if (!resp_found) begin
          resp_found = 1'b1;
          resp_idx   = scan_idx;
        end
      end
    end
  end

  assign take_discard = data_ok && (discard_q != '0);
  assign take_entry   = data_ok && (discard_q == '0) && resp_found;

  // Responses still owed to flushed entries, plus any earlier backlog not yet drained.
  always_comb begin
    disc_sum = (CntW+1)'(discard_q) + (CntW+1)'(pending)
             - (CntW+1)'(take_discard) - (CntW+1)'(take_entry);
    disc_flush = (disc_sum > (CntW+1)'(DEPTH)) ? CntW'(DEPTH) : disc_sum[CntW-1:0];
  end

  assign head_ent   = ent_q[rptr_q];
  assign head_hit   = take_entry && (resp_idx == rptr_q);
  assign head_done  = valid_q[rptr_q] && (!head_ent.wait_ok || recv_q[rptr_q] || head_hit);
  assign head_rdata = recv_q[rptr_q] ? data_q[rptr_q] : rdata;

  assign active    = resetn && !flush && (count_q != '0);
  assign in_ready  = resetn && (count_q < CntW'(DEPTH));
  assign out_valid = active && head_done;
  assign enq       = in_valid && in_ready && !flush;
  assign deq       = out_valid && out_ready;

  always_comb begin
    valid_d   = valid_q;
    recv_d    = recv_q;
    wptr_d    = wptr_q;
    rptr_d    = rptr_q;
    count_d   = count_q;
    discard_d = discard_q;
    if (flush) begin
      valid_d   = '0;
      recv_d    = '0;
      wptr_d    = '0;
      rptr_d    = '0;
      count_d   = '0;
      discard_d = disc_flush;
    end else begin
      if (take_discard) discard_d = discard_q - 1'b1;
      if (take_entry) recv_d[resp_idx] = 1'b1;
      if (deq) begin
        valid_d[rptr_q] = 1'b0;
        recv_d[rptr_q]  = 1'b0;
        rptr_d          = rptr_q + 1'b1;
      end
      if (enq) begin
        valid_d[wptr_q] = 1'b1;
        recv_d[wptr_q]  = 1'b0;
        wptr_d          = wptr_q + 1'b1;
      end
      count_d = count_q + CntW'(enq) - CntW'(deq);
    end
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      valid_q   <= '0;
      recv_q    <= '0;
      wptr_q    <= '0;
      rptr_q    <= '0;
      count_q   <= '0;
      discard_q <= '0;
    end else begin
      valid_q   <= valid_d;
      recv_q    <= recv_d;
      wptr_q    <= wptr_d;
      rptr_q    <= rptr_d;
      count_q   <= count_d;
      discard_q <= discard_d;
    end
  end

  // Payload needs no reset: valid/recv flags qualify every read.
  always_ff @(posedge clk) begin
    if (enq) begin
      ent_q[wptr_q]  <= '{wait_ok:      in_wait_ok,
                          mem_op:       in_mem_op,
                          res_from_mem: in_res_from_mem,
                          rf_we:        in_rf_we,
                          rf_waddr:     in_rf_waddr,
                          alu_result:   in_alu_result,
                          ex:           in_ex};
      info_q[wptr_q] <= in_info;
    end
    if (take_entry) begin
      data_q[resp_idx] <= rdata;
    end
  end

  load_align u_load_align (
    .mem_op  (head_ent.mem_op),
    .addr_lo (head_ent.alu_result[1:0]),
    .rdata   (head_rdata),
    .data    (load_data)
  );

  assign out_rf_we    = head_ent.rf_we;
  assign out_rf_waddr = head_ent.rf_waddr;
  assign out_rf_wdata = head_ent.res_from_mem ? load_data : head_ent.alu_result;
  assign out_ex       = head_ent.ex;
  assign out_info     = info_q[rptr_q];

  // Forwarding looks at the youngest entry; load data is never forwarded, only flagged pending.
  assign young_idx        = wptr_q - 1'b1;
  assign young_ent        = ent_q[young_idx];
  assign fwd_we           = active && valid_q[young_idx] && young_ent.rf_we;
  assign fwd_waddr        = young_ent.rf_waddr;
  assign fwd_wdata        = young_ent.alu_result;
  assign fwd_load_pending = active && valid_q[young_idx] && young_ent.wait_ok
                            && !recv_q[young_idx];

  always_comb begin
    mem_ex_any = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      if (valid_q[i] && ent_q[i].ex) mem_ex_any = 1'b1;
    end
    mem_ex_any = mem_ex_any && active;
  end

endmodule

// File: tb/tb_mem_stage_q.sv
// Directed self-checking bench for mem_stage_q (DEPTH=4): alignment, ordering, flush discard, reset.
module tb_mem_stage_q;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned INFO_W = 64;

  logic              clk = 1'b0;
  logic              resetn, flush, in_valid, in_ready, in_wait_ok, in_res_from_mem;
  logic              in_rf_we, in_ex, data_ok, out_valid, out_ready, out_rf_we, out_ex;
  logic [3:0]        in_mem_op;
  logic [4:0]        in_rf_waddr, out_rf_waddr, fwd_waddr;
  logic [31:0]       in_alu_result, rdata, out_rf_wdata, fwd_wdata;
  logic [INFO_W-1:0] in_info, out_info;
  logic              fwd_we, fwd_load_pending, mem_ex_any;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_stage_q #(.DEPTH(DEPTH), .INFO_W(INFO_W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .flush            (flush),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_wait_ok       (in_wait_ok),
    .in_mem_op        (in_mem_op),
    .in_res_from_mem  (in_res_from_mem),
    .in_rf_we         (in_rf_we),
    .in_rf_waddr      (in_rf_waddr),
    .in_alu_result    (in_alu_result),
    .in_ex            (in_ex),
    .in_info          (in_info),
    .data_ok          (data_ok),
    .rdata            (rdata),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_rf_we        (out_rf_we),
    .out_rf_waddr     (out_rf_waddr),
    .out_rf_wdata     (out_rf_wdata),
    .out_ex           (out_ex),
    .out_info         (out_info),
    .fwd_we           (fwd_we),
    .fwd_waddr        (fwd_waddr),
    .fwd_wdata        (fwd_wdata),
    .fwd_load_pending (fwd_load_pending),
    .mem_ex_any       (mem_ex_any)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    flush = 0; in_valid = 0; in_wait_ok = 0; in_mem_op = 0; in_res_from_mem = 0;
    in_rf_we = 0; in_rf_waddr = 0; in_alu_result = 0; in_ex = 0; in_info = '0;
    data_ok = 0; rdata = 0; out_ready = 0;
  endtask

  task automatic drive_enq(input logic wok, input logic [3:0] op, input logic rfm,
                           input logic [4:0] wa, input logic [31:0] alu, input logic ex);
    in_valid = 1; in_wait_ok = wok; in_mem_op = op; in_res_from_mem = rfm; in_rf_we = 1;
    in_rf_waddr = wa; in_alu_result = alu; in_ex = ex;
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    step(); step();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_out_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rst_in_ready: got %0b want 0", in_ready); end
    checks++; if (fwd_we !== 1'b0) begin errors++; $display("FAIL rst_fwd_we: got %0b want 0", fwd_we); end
    checks++; if (fwd_load_pending !== 1'b0) begin errors++; $display("FAIL rst_fwd_lp: got %0b want 0", fwd_load_pending); end
    checks++; if (mem_ex_any !== 1'b0) begin errors++; $display("FAIL rst_ex_any: got %0b want 0", mem_ex_any); end
    resetn = 1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL rst_release_in_ready: got %0b want 1", in_ready); end
    step();
  endtask

  task automatic test_ldb_bypass();
    in_info = 64'hDEAD_BEEF_0000_1003;
    drive_enq(1, 4'd0, 1, 5'd5, 32'h0000_1003, 0);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldb_enq_cycle_valid: got %0b want 0", out_valid); end
    step();
    in_valid = 0;
    #1;
    checks++; if (fwd_load_pending !== 1'b1) begin errors++; $display("FAIL ldb_fwd_lp: got %0b want 1", fwd_load_pending); end
    checks++; if (fwd_wdata !== 32'h0000_1003) begin errors++; $display("FAIL ldb_fwd_wdata: got %h want 00001003", fwd_wdata); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldb_wait_valid: got %0b want 0", out_valid); end
    data_ok = 1; rdata = 32'h80FF_0000; out_ready = 1;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ldb_bypass_valid: got %0b want 1", out_valid); end
    checks++; if (out_rf_wdata !== 32'hFFFF_FF80) begin errors++; $display("FAIL ldb_wdata: got %h want ffffff80", out_rf_wdata); end
    checks++; if (out_rf_waddr !== 5'd5) begin errors++; $display("FAIL ldb_waddr: got %0d want 5", out_rf_waddr); end
    checks++; if (out_info !== 64'hDEAD_BEEF_0000_1003) begin errors++; $display("FAIL ldb_info: got %h want deadbeef00001003", out_info); end
    step();
    data_ok = 0; out_ready = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ldb_after_valid: got %0b want 0", out_valid); end
    step();
  endtask

  task automatic test_fill_drain();
    out_ready = 0;
    for (int i = 0; i < 4; i++) begin
      drive_enq(1, 4'd2, 1, 5'(i + 1), 32'h100 + 32'(4 * i), 0);
      step();
    end
    drive_enq(1, 4'd2, 1, 5'd31, 32'h0000_0500, 0);
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL fill_full_in_ready: got %0b want 0", in_ready); end
    step();
    in_valid = 0;
    for (int i = 0; i < 4; i++) begin
      data_ok = 1; rdata = 32'hA000_0000 + 32'(i);
      step();
    end
    data_ok = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL fill_stored_valid: got %0b want 1", out_valid); end
    checks++; if (fwd_load_pending !== 1'b0) begin errors++; $display("FAIL fill_fwd_lp: got %0b want 0", fwd_load_pending); end
    out_ready = 1;
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL drain_valid[%0d]: got %0b want 1", i, out_valid); end
      checks++; if (out_rf_waddr !== 5'(i + 1)) begin errors++; $display("FAIL drain_waddr[%0d]: got %0d want %0d", i, out_rf_waddr, i + 1); end
      checks++; if (out_rf_wdata !== 32'hA000_0000 + 32'(i)) begin errors++; $display("FAIL drain_wdata[%0d]: got %h want %h", i, out_rf_wdata, 32'hA000_0000 + 32'(i)); end
      step();
    end
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL drain_empty_valid: got %0b want 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL drain_empty_in_ready: got %0b want 1", in_ready); end
    out_ready = 0;
    step();
  endtask

  task automatic test_flush_discard();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(1, 4'd2, 1, 5'(10 + i), 32'h200 + 32'(4 * i), 0);
      step();
    end
    in_valid = 0; data_ok = 1; rdata = 32'h1111_1111; flush = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_gate_valid: got %0b want 0", out_valid); end
    step();
    flush = 0; data_ok = 0;
    #1;
    checks++; if (dut.discard_q !== 3'd2) begin errors++; $display("FAIL flush_discard: got %0d want 2", dut.discard_q); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %0b want 1", in_ready); end
    drive_enq(1, 4'd2, 1, 5'd9, 32'h0000_0300, 0);
    data_ok = 1; rdata = 32'h2222_2222;
    step();
    in_valid = 0; data_ok = 1; rdata = 32'h2222_3333; out_ready = 1;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop2_valid: got %0b want 0", out_valid); end
    step();
    data_ok = 1; rdata = 32'h3333_CAFE;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_new_valid: got %0b want 1", out_valid); end
    checks++; if (out_rf_wdata !== 32'h3333_CAFE) begin errors++; $display("FAIL flush_new_wdata: got %h want 3333cafe", out_rf_wdata); end
    checks++; if (out_rf_waddr !== 5'd9) begin errors++; $display("FAIL flush_new_waddr: got %0d want 9", out_rf_waddr); end
    step();
    data_ok = 0; out_ready = 0;
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_end_valid: got %0b want 0", out_valid); end
    step();
  endtask

  task automatic test_align();
    logic [3:0]  ops   [9];
    logic [31:0] addrs [9];
    logic [31:0] rds   [9];
    logic [31:0] exps  [9];
    logic        rfm   [9];
    ops   = '{4'd9, 4'd5, 4'd1, 4'd1, 4'd8, 4'd0, 4'd2, 4'd0, 4'd2};
    addrs = '{32'h2002, 32'h2000, 32'h2002, 32'h2000, 32'h2001, 32'h2001, 32'h2000, 32'h2000,
              32'h0000_ABCD};
    rds   = '{32'hBEEF_1234, 32'hBEEF_1234, 32'hBEEF_1234, 32'hBEEF_1234, 32'h1234_F678,
              32'h1234_F678, 32'h1234_F678, 32'h1234_F678, 32'h9999_9999};
    exps  = '{32'h0000_BEEF, 32'h0000_0000, 32'hFFFF_BEEF, 32'h0000_1234, 32'h0000_00F6,
              32'hFFFF_FFF6, 32'h1234_F678, 32'h0000_0078, 32'h0000_ABCD};
    rfm   = '{1, 1, 1, 1, 1, 1, 1, 1, 0};
    out_ready = 1;
    for (int k = 0; k < 9; k++) begin
      drive_enq(1, ops[k], rfm[k], 5'd3, addrs[k], 0);
      step();
      in_valid = 0; data_ok = 1; rdata = rds[k];
      #1;
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL align_valid[%0d]: got %0b want 1", k, out_valid); end
      checks++; if (out_rf_wdata !== exps[k]) begin errors++; $display("FAIL align_wdata[%0d]: got %h want %h", k, out_rf_wdata, exps[k]); end
      step();
      data_ok = 0;
    end
    out_ready = 0;
    step();
  endtask

  task automatic test_reset_discard();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_enq(1, 4'd2, 1, 5'(16 + i), 32'h0000_0600, 0);
      step();
    end
    in_valid = 0; flush = 1;
    step();
    flush = 0;
    #1;
    checks++; if (dut.discard_q !== 3'd3) begin errors++; $display("FAIL rstdisc_loaded: got %0d want 3", dut.discard_q); end
    resetn = 0; flush = 1; data_ok = 1; rdata = 32'h4444_4444;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL rstdisc_in_ready: got %0b want 0", in_ready); end
    step();
    resetn = 1; flush = 0; data_ok = 0;
    #1;
    checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL rstdisc_cleared: got %0d want 0", dut.discard_q); end
    data_ok = 1; rdata = 32'h5555_5555;
    step();
    data_ok = 0;
    #1;
    checks++; if (dut.discard_q !== 3'd0) begin errors++; $display("FAIL rstdisc_stray_ignored: got %0d want 0", dut.discard_q); end
    drive_enq(1, 4'd2, 1, 5'd4, 32'h0000_0400, 0);
    out_ready = 1;
    step();
    in_valid = 0; data_ok = 1; rdata = 32'h6666_7777;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL rstdisc_next_valid: got %0b want 1", out_valid); end
    checks++; if (out_rf_wdata !== 32'h6666_7777) begin errors++; $display("FAIL rstdisc_next_wdata: got %h want 66667777", out_rf_wdata); end
    step();
    data_ok = 0; out_ready = 0;
    step();
  endtask

  task automatic test_nonload_order();
    out_ready = 1;
    drive_enq(0, 4'd0, 0, 5'd20, 32'h0000_0055, 1);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL nl_same_cycle_valid: got %0b want 0", out_valid); end
    step();
    in_valid = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL nl_next_cycle_valid: got %0b want 1", out_valid); end
    checks++; if (out_ex !== 1'b1) begin errors++; $display("FAIL nl_out_ex: got %0b want 1", out_ex); end
    checks++; if (mem_ex_any !== 1'b1) begin errors++; $display("FAIL nl_ex_any: got %0b want 1", mem_ex_any); end
    checks++; if (out_rf_wdata !== 32'h0000_0055) begin errors++; $display("FAIL nl_wdata: got %h want 00000055", out_rf_wdata); end
    step();
    out_ready = 0;
    #1;
    checks++; if (mem_ex_any !== 1'b0) begin errors++; $display("FAIL nl_ex_any_clear: got %0b want 0", mem_ex_any); end
    drive_enq(1, 4'd2, 1, 5'd7, 32'h0000_0040, 0);
    step();
    in_valid = 0;
    #1;
    checks++; if (fwd_waddr !== 5'd7) begin errors++; $display("FAIL ord_fwd_waddr_ld: got %0d want 7", fwd_waddr); end
    checks++; if (fwd_load_pending !== 1'b1) begin errors++; $display("FAIL ord_fwd_lp_ld: got %0b want 1", fwd_load_pending); end
    drive_enq(0, 4'd0, 0, 5'd8, 32'h0000_0058, 0);
    step();
    in_valid = 0;
    #1;
    checks++; if (fwd_waddr !== 5'd8) begin errors++; $display("FAIL ord_fwd_waddr_nl: got %0d want 8", fwd_waddr); end
    checks++; if (fwd_wdata !== 32'h0000_0058) begin errors++; $display("FAIL ord_fwd_wdata_nl: got %h want 00000058", fwd_wdata); end
    checks++; if (fwd_load_pending !== 1'b0) begin errors++; $display("FAIL ord_fwd_lp_nl: got %0b want 0", fwd_load_pending); end
    checks++; if (fwd_we !== 1'b1) begin errors++; $display("FAIL ord_fwd_we: got %0b want 1", fwd_we); end
    out_ready = 1;
    for (int c = 0; c < 2; c++) begin
      #1;
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ord_blocked_valid[%0d]: got %0b want 0", c, out_valid); end
      step();
    end
    data_ok = 1; rdata = 32'h0000_0077;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ord_ld_valid: got %0b want 1", out_valid); end
    checks++; if (out_rf_waddr !== 5'd7) begin errors++; $display("FAIL ord_ld_waddr: got %0d want 7", out_rf_waddr); end
    checks++; if (out_rf_wdata !== 32'h0000_0077) begin errors++; $display("FAIL ord_ld_wdata: got %h want 00000077", out_rf_wdata); end
    step();
    data_ok = 0;
    #1;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ord_nl_valid: got %0b want 1", out_valid); end
    checks++; if (out_rf_waddr !== 5'd8) begin errors++; $display("FAIL ord_nl_waddr: got %0d want 8", out_rf_waddr); end
    checks++; if (out_rf_wdata !== 32'h0000_0058) begin errors++; $display("FAIL ord_nl_wdata: got %h want 00000058", out_rf_wdata); end
    step();
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ord_end_valid: got %0b want 0", out_valid); end
    out_ready = 0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached before completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_ldb_bypass();
    test_fill_drain();
    test_flush_discard();
    test_align();
    test_reset_discard();
    test_nonload_order();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
